// File: rtl/byte_pack_pkg.sv
// Shared types and helpers for the byte-to-word packer and its word store.
package byte_pack_pkg;

   typedef logic [31:0] word_t;
   typedef logic [2:0]  bcnt_t;

   localparam int BYTES_PER_WORD = 4;

   function automatic word_t bswap32(input word_t w);
      word_t r;
      r = {<<8{w}};
      return r;
   endfunction

endpackage

// File: rtl/byte_pack_mem.sv
// Word store for the packer: circular buffer of words plus byte counts, with occupancy.
module byte_pack_mem
   import byte_pack_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  word_t         push_word,
   input  bcnt_t         push_bytes,
   input  logic          pop,
   output word_t         head_word,
   output bcnt_t         head_bytes,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   word_t         mem_word  [0:DEPTH-1];
   bcnt_t         mem_bytes [0:DEPTH-1];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;

   // Storage is intentionally left unreset; only pointers and occupancy clear.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_word[wr_ptr[AW-1:0]]  <= push_word;
         mem_bytes[wr_ptr[AW-1:0]] <= push_bytes;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   assign full       = (level == LW'(DEPTH));
   assign empty      = (level == '0);
   assign head_word  = mem_word[rd_ptr[AW-1:0]];
   assign head_bytes = mem_bytes[rd_ptr[AW-1:0]];

endmodule

// File: rtl/byte_pack_fifo.sv
// Packs a byte stream into little-endian 32-bit words and queues them on a valid/ready output.
module byte_pack_fifo
   import byte_pack_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter bit BSWAP = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_data,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_data,
   output logic [2:0]               out_bytes,
   output logic [$clog2(DEPTH):0]   level
);

   logic [1:0] cnt;
   word_t      acc;
   word_t      commit_word;
   word_t      head_word;
   bcnt_t      head_bytes;
   logic       full;
   logic       empty;
   logic       accept;
   logic       commit;
   logic       pop;

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign accept    = in_valid && in_ready;
   assign commit    = accept && ((cnt == 2'(BYTES_PER_WORD - 1)) || in_last);
   assign pop       = out_valid && out_ready;

   // Merge the current byte and clear any lanes beyond it for early-closed words.
   always_comb begin
      commit_word = acc;
      commit_word[cnt*8 +: 8] = in_data;
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
         if (i > cnt) commit_word[i*8 +: 8] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         acc <= '0;
      end else if (accept) begin
         if (commit) begin
            cnt <= '0;
            acc <= '0;
         end else begin
            acc[cnt*8 +: 8] <= in_data;
            cnt             <= cnt + 2'd1;
         end
      end
   end

   byte_pack_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (commit),
      .push_word  (commit_word),
      .push_bytes ({1'b0, cnt} + 3'd1),
      .pop        (pop),
      .head_word  (head_word),
      .head_bytes (head_bytes),
      .full       (full),
      .empty      (empty),
      .level      (level)
   );

   assign out_data  = BSWAP ? bswap32(head_word) : head_word;
   assign out_bytes = head_bytes;

endmodule
